// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch stage: datapath width, reset PC,
// FSM state encoding and the IF/ID bundle carried to decode.
package fetch_unit_pkg;

    localparam int              WORD_SIZE        = 16;
    localparam logic [16-1:0]   RESET_PC_DEFAULT = 16'h0000;

    // IDLE: one settling cycle after reset.
    // WAIT: a memory request is outstanding (i_readM=1).
    // HOLD: a completed fetch is parked while decode is stalled.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } fetch_state_e;

    // One fetched instruction plus the context EX needs to verify the prediction.
    typedef struct packed {
        logic [WORD_SIZE-1:0] inst;
        logic [WORD_SIZE-1:0] pc;
        logic [WORD_SIZE-1:0] pred_pc;
    } if_id_bundle_t;

endpackage

// File: rtl/fetch_unit_if_id_latch.sv
// IF/ID pipeline register.
// Ports:
//   clk, reset_n  clock / async active-low reset
//   flush         drop the live instruction (redirect); wins over everything
//   load          capture d as a new live instruction
//   stall         decode is stalled: keep contents and valid as they are
//   d             incoming bundle
//   valid, q      registered valid flag and bundle
// With no load and no stall the register empties, so an instruction is presented
// to decode for exactly one unstalled cycle.
module fetch_unit_if_id_latch
    import fetch_unit_pkg::*;
(
    input  logic          clk,
    input  logic          reset_n,
    input  logic          flush,
    input  logic          load,
    input  logic          stall,
    input  if_id_bundle_t d,
    output logic          valid,
    output if_id_bundle_t q
);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid <= 1'b0;
            q     <= '0;
        end else if (flush) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            q     <= d;
        end else if (!stall) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, talks to instruction memory over a
// variable-latency req/ready handshake and fills the IF/ID latch.
// Ports:
//   clk, reset_n                     clock / async active-low reset
//   i_readM, i_address               memory request and address (address = pc)
//   i_data, i_ready                  memory reply
//   pred_pc, prediction              PC to the predictor / its next-PC guess
//   stall                            hazard unit: hold IF/ID, do not advance
//   redirect, redirect_pc            EX mispredict: flush and restart
//   if_id_valid, if_id_inst,
//   if_id_pc, if_id_pred_pc          IF/ID latch contents
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [WORD_SIZE-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic                 clk,
    input  logic                 reset_n,
    output logic                 i_readM,
    output logic [WORD_SIZE-1:0] i_address,
    input  logic [WORD_SIZE-1:0] i_data,
    input  logic                 i_ready,
    output logic [WORD_SIZE-1:0] pred_pc,
    input  logic [WORD_SIZE-1:0] prediction,
    input  logic                 stall,
    input  logic                 redirect,
    input  logic [WORD_SIZE-1:0] redirect_pc,
    output logic                 if_id_valid,
    output logic [WORD_SIZE-1:0] if_id_inst,
    output logic [WORD_SIZE-1:0] if_id_pc,
    output logic [WORD_SIZE-1:0] if_id_pred_pc
);

    fetch_state_e         state_q, state_d;
    logic [WORD_SIZE-1:0] pc_q, pc_d;
    // kill marks the outstanding request as stale: a redirect arrived while the
    // memory was still busy, and a request cannot be withdrawn mid-flight.
    logic                 kill_q, kill_d;
    logic [WORD_SIZE-1:0] pend_q, pend_d;
    if_id_bundle_t        hold_q, hold_d;

    logic                 ld;
    if_id_bundle_t        ld_data;
    if_id_bundle_t        if_id_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
            kill_q  <= 1'b0;
            pend_q  <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            kill_q  <= kill_d;
            pend_q  <= pend_d;
            hold_q  <= hold_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        kill_d  = kill_q;
        pend_d  = pend_q;
        hold_d  = hold_q;
        ld      = 1'b0;
        ld_data = '0;
        case (state_q)
            S_IDLE: begin
                state_d = S_WAIT;
                if (redirect) pc_d = redirect_pc;
            end
            S_WAIT: begin
                if (redirect) begin
                    if (i_ready) begin
                        // Reply is landing this edge anyway: discard it and restart.
                        pc_d   = redirect_pc;
                        kill_d = 1'b0;
                    end else begin
                        // Keep the address stable; remember where to go once it lands.
                        kill_d = 1'b1;
                        pend_d = redirect_pc;
                    end
                end else if (i_ready) begin
                    if (kill_q) begin
                        pc_d   = pend_q;
                        kill_d = 1'b0;
                    end else if (!stall) begin
                        ld      = 1'b1;
                        ld_data = '{inst: i_data, pc: pc_q, pred_pc: prediction};
                        pc_d    = prediction;
                    end else begin
                        hold_d  = '{inst: i_data, pc: pc_q, pred_pc: prediction};
                        pc_d    = prediction;
                        state_d = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (redirect) begin
                    pc_d    = redirect_pc;
                    kill_d  = 1'b0;
                    hold_d  = '0;
                    state_d = S_WAIT;
                end else if (!stall) begin
                    ld      = 1'b1;
                    ld_data = hold_q;
                    hold_d  = '0;
                    state_d = S_WAIT;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    fetch_unit_if_id_latch u_if_id_latch (
        .clk     (clk),
        .reset_n (reset_n),
        .flush   (redirect),
        .load    (ld),
        .stall   (stall),
        .d       (ld_data),
        .valid   (if_id_valid),
        .q       (if_id_q)
    );

    assign i_readM       = (state_q == S_WAIT);
    assign i_address     = pc_q;
    assign pred_pc       = pc_q;
    assign if_id_inst    = if_id_q.inst;
    assign if_id_pc      = if_id_q.pc;
    assign if_id_pred_pc = if_id_q.pred_pc;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        i_readM;
    logic [15:0] i_address;
    logic [15:0] i_data;
    logic        i_ready;
    logic [15:0] pred_pc;
    logic [15:0] prediction;
    logic        stall;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        if_id_valid;
    logic [15:0] if_id_inst;
    logic [15:0] if_id_pc;
    logic [15:0] if_id_pred_pc;

    always #5 clk = ~clk;

    // Next-line predictor stand-in.
    assign prediction = pred_pc + 16'd1;

    fetch_unit dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .i_readM       (i_readM),
        .i_address     (i_address),
        .i_data        (i_data),
        .i_ready       (i_ready),
        .pred_pc       (pred_pc),
        .prediction    (prediction),
        .stall         (stall),
        .redirect      (redirect),
        .redirect_pc   (redirect_pc),
        .if_id_valid   (if_id_valid),
        .if_id_inst    (if_id_inst),
        .if_id_pc      (if_id_pc),
        .if_id_pred_pc (if_id_pred_pc)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Instruction memory contents as a pure function of address.
    function automatic logic [15:0] memf(input logic [15:0] a);
        return {a[7:0], a[15:8]} ^ 16'h5A3C;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, " readM"}, {31'b0, i_readM}, 32'd0);
        chk({tag, " addr"},  {16'b0, i_address}, 32'd0);
        chk({tag, " valid"}, {31'b0, if_id_valid}, 32'd0);
        chk({tag, " pc"},    {16'b0, if_id_pc}, 32'd0);
        chk({tag, " inst"},  {16'b0, if_id_inst}, 32'd0);
        chk({tag, " pred"},  {16'b0, if_id_pred_pc}, 32'd0);
    endtask

    typedef struct {
        logic        rdy, stl, rd;
        logic [15:0] rpc;
        logic        e_rd;
        logic [15:0] e_addr;
        logic        e_v;
        logic [15:0] e_pc;
    } vec_t;

    function automatic vec_t mk(input logic e_rd, input logic [15:0] e_addr, input logic e_v,
                                input logic [15:0] e_pc, input logic rdy, input logic stl,
                                input logic rd, input logic [15:0] rpc);
        vec_t v;
        v.e_rd = e_rd; v.e_addr = e_addr; v.e_v = e_v; v.e_pc = e_pc;
        v.rdy = rdy; v.stl = stl; v.rd = rd; v.rpc = rpc;
        return v;
    endfunction

    vec_t tbl[26];

    initial begin
        logic [15:0] exp_pc;
        int          lat;
        int          idle;
        int          consumed;
        logic        was_pending;
        logic [15:0] pend_addr;

        // Each row: outputs expected this cycle, then inputs applied this cycle.
        //              rdM addr     v  if_id_pc  rdy stl rd rpc
        tbl[0]  = mk(0, 16'h0000, 0, 16'h0000, 0, 0, 0, 16'h0000);
        tbl[1]  = mk(1, 16'h0000, 0, 16'h0000, 1, 0, 0, 16'h0000);
        tbl[2]  = mk(1, 16'h0001, 1, 16'h0000, 1, 0, 0, 16'h0000);
        tbl[3]  = mk(1, 16'h0002, 1, 16'h0001, 1, 0, 0, 16'h0000);
        tbl[4]  = mk(1, 16'h0003, 1, 16'h0002, 1, 0, 0, 16'h0000);
        tbl[5]  = mk(1, 16'h0004, 1, 16'h0003, 0, 0, 0, 16'h0000);
        tbl[6]  = mk(1, 16'h0004, 0, 16'h0000, 0, 0, 0, 16'h0000);
        tbl[7]  = mk(1, 16'h0004, 0, 16'h0000, 1, 0, 0, 16'h0000);
        tbl[8]  = mk(1, 16'h0005, 1, 16'h0004, 0, 1, 0, 16'h0000);
        tbl[9]  = mk(1, 16'h0005, 1, 16'h0004, 1, 1, 0, 16'h0000);
        tbl[10] = mk(0, 16'h0006, 1, 16'h0004, 0, 1, 0, 16'h0000);
        tbl[11] = mk(0, 16'h0006, 1, 16'h0004, 0, 1, 0, 16'h0000);
        tbl[12] = mk(0, 16'h0006, 1, 16'h0004, 0, 0, 0, 16'h0000);
        tbl[13] = mk(1, 16'h0006, 1, 16'h0005, 0, 0, 1, 16'h0040);
        tbl[14] = mk(1, 16'h0006, 0, 16'h0000, 0, 0, 0, 16'h0000);
        tbl[15] = mk(1, 16'h0006, 0, 16'h0000, 1, 0, 0, 16'h0000);
        tbl[16] = mk(1, 16'h0040, 0, 16'h0000, 1, 0, 0, 16'h0000);
        tbl[17] = mk(1, 16'h0041, 1, 16'h0040, 1, 1, 0, 16'h0000);
        tbl[18] = mk(0, 16'h0042, 1, 16'h0040, 0, 1, 1, 16'h0080);
        tbl[19] = mk(1, 16'h0080, 0, 16'h0000, 1, 0, 0, 16'h0000);
        tbl[20] = mk(1, 16'h0081, 1, 16'h0080, 0, 0, 0, 16'h0000);
        tbl[21] = mk(1, 16'h0081, 0, 16'h0000, 1, 0, 1, 16'hFFFF);
        tbl[22] = mk(1, 16'hFFFF, 0, 16'h0000, 1, 0, 0, 16'h0000);
        tbl[23] = mk(1, 16'h0000, 1, 16'hFFFF, 0, 0, 0, 16'h0000);
        tbl[24] = mk(1, 16'h0000, 0, 16'h0000, 1, 0, 0, 16'h0000);
        tbl[25] = mk(1, 16'h0001, 1, 16'h0000, 1, 0, 0, 16'h0000);

        reset_n = 1'b0; i_ready = 1'b0; i_data = '0;
        stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
        repeat (2) @(negedge clk);
        chk_reset_vals("reset");

        // Directed table: zero-wait, 3-cycle latency, stall/hold, killed reply,
        // redirect+stall with a held instruction, wrap through FFFF.
        reset_n = 1'b1;
        for (int r = 0; r < 26; r++) begin
            chk($sformatf("row%0d readM", r), {31'b0, i_readM}, {31'b0, tbl[r].e_rd});
            chk($sformatf("row%0d addr", r), {16'b0, i_address}, {16'b0, tbl[r].e_addr});
            chk($sformatf("row%0d pred_pc", r), {16'b0, pred_pc}, {16'b0, tbl[r].e_addr});
            chk($sformatf("row%0d valid", r), {31'b0, if_id_valid}, {31'b0, tbl[r].e_v});
            if (tbl[r].e_v) begin
                chk($sformatf("row%0d if_id_pc", r), {16'b0, if_id_pc}, {16'b0, tbl[r].e_pc});
                chk($sformatf("row%0d inst", r), {16'b0, if_id_inst}, {16'b0, memf(tbl[r].e_pc)});
                chk($sformatf("row%0d if_id_pred", r), {16'b0, if_id_pred_pc},
                    {16'b0, tbl[r].e_pc + 16'd1});
            end
            i_ready     = tbl[r].rdy;
            i_data      = memf(i_address);
            stall       = tbl[r].stl;
            redirect    = tbl[r].rd;
            redirect_pc = tbl[r].rpc;
            @(negedge clk);
        end

        // Reset pulsed mid-fetch with a live IF/ID entry.
        chk("pre_reset valid", {31'b0, if_id_valid}, 32'd1);
        chk("pre_reset addr", {16'b0, i_address}, 32'h2);
        i_ready = 1'b0; stall = 1'b0; redirect = 1'b0;
        #2 reset_n = 1'b0;
        #1 chk_reset_vals("async_reset");
        i_ready = 1'b1; i_data = 16'hDEAD;
        @(posedge clk);
        #1 chk_reset_vals("in_reset");
        @(negedge clk);
        reset_n = 1'b1;
        chk("rst_idle readM", {31'b0, i_readM}, 32'd0);
        i_ready = 1'b1; i_data = 16'hBEEF;
        @(negedge clk);
        chk("rst_wait readM", {31'b0, i_readM}, 32'd1);
        chk("rst_wait addr", {16'b0, i_address}, 32'd0);
        chk("rst_wait valid", {31'b0, if_id_valid}, 32'd0);
        i_ready = 1'b1; i_data = memf(i_address);
        @(negedge clk);
        chk("rst_first valid", {31'b0, if_id_valid}, 32'd1);
        chk("rst_first pc", {16'b0, if_id_pc}, 32'd0);
        chk("rst_first inst", {16'b0, if_id_inst}, {16'b0, memf(16'h0000)});
        chk("rst_first addr", {16'b0, i_address}, 32'd1);

        // Random phase: stream-level model. Decode consumes an instruction on any
        // cycle with valid & ~stall & ~redirect; consumed PCs must follow the
        // predicted sequence, restarting at each redirect target.
        i_ready = 1'b0; stall = 1'b0; redirect = 1'b0;
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        exp_pc = 16'h0000; lat = $urandom_range(0, 3);
        idle = 0; consumed = 0; was_pending = 1'b0; pend_addr = '0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (was_pending) begin
                chk("rand req_held", {31'b0, i_readM}, 32'd1);
                chk("rand addr_stable", {16'b0, i_address}, {16'b0, pend_addr});
            end
            if (i_readM) begin
                if (lat == 0) begin
                    i_ready = 1'b1;
                    i_data  = memf(i_address);
                    lat     = $urandom_range(0, 3);
                end else begin
                    i_ready = 1'b0;
                    i_data  = 16'($urandom);
                    lat--;
                end
            end else begin
                i_ready = 1'($urandom_range(0, 1));
                i_data  = 16'($urandom);
            end
            stall    = ($urandom_range(0, 99) < 30);
            redirect = ($urandom_range(0, 99) < 6);
            if ($urandom_range(0, 3) == 0) redirect_pc = 16'hFFFC + 16'($urandom_range(0, 3));
            else                           redirect_pc = 16'($urandom);
            was_pending = i_readM && !i_ready;
            pend_addr   = i_address;

            if (redirect) begin
                exp_pc = redirect_pc;
                idle   = 0;
            end else if (if_id_valid && !stall) begin
                chk("rand pc", {16'b0, if_id_pc}, {16'b0, exp_pc});
                chk("rand inst", {16'b0, if_id_inst}, {16'b0, memf(exp_pc)});
                chk("rand pred", {16'b0, if_id_pred_pc}, {16'b0, exp_pc + 16'd1});
                exp_pc = exp_pc + 16'd1;
                consumed++;
                idle = 0;
            end else if (!stall) begin
                idle++;
                chk("rand liveness", {31'b0, idle > 16}, 32'd0);
                if (idle > 16) idle = 0;
            end
            @(negedge clk);
        end
        chk("rand consumed_enough", {31'b0, consumed >= 200}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
